tcm_arbiter: RTL and testbench
==============================

TCM_ARBITER -- requirements
Module: tcm_arbiter

Interface
REQ-001 SHALL have parameters: AW, 32, byte-address width; DW, 32, data width; MW, 4, byte-mask width; RAM_AW, 9, RAM word-address width; STARVE_LIM, 4, consecutive IFU losses before IFU is forced to win.
REQ-002 SHALL have one clock and a synchronous active-high reset; ports, clock and reset first:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  fetch read request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_req_addr  in  AW  fetch byte address
ifu_rsp_valid  out  1  fetch data valid
ifu_rsp_ready  in  1  fetch data accepted
ifu_rsp_rdata  out  DW  fetch data
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  AW  LSU byte address
lsu_req_we  in  1  1=store, 0=load
lsu_req_wem  in  MW  store byte mask
lsu_req_wdata  in  DW  store data
lsu_rsp_valid  out  1  LSU response valid (load data or store ack)
lsu_rsp_ready  in  1  LSU response accepted
lsu_rsp_rdata  out  DW  load data (0 for stores)
ram_addr  out  RAM_AW  RAM word address
ram_din  out  DW  RAM write data
ram_we  out  1  RAM write enable
ram_wem  out  MW  RAM byte mask
ram_dout  in  DW  RAM read data, valid one cycle after a read address is presented

Function
REQ-003 SHALL be a two-state FSM: IDLE (no response outstanding), BUSY (one response outstanding, owner recorded in a 1-bit owner register).
REQ-004 SHALL treat a grant slot as open when the state is IDLE, or when the state is BUSY and the outstanding response handshakes this cycle (rsp_valid & rsp_ready of the owner).
REQ-005 SHALL, in an open slot, grant one requester: LSU over IFU, except that IFU wins when starve_cnt == STARVE_LIM.
REQ-006 SHALL assert exactly one of ifu_req_ready/lsu_req_ready, combinationally, only for the granted requester; both SHALL be 0 when no slot is open.
REQ-007 SHALL drive ram_addr = granted addr[RAM_AW+1:2]; the value of addr[1:0] SHALL be ignored.
REQ-008 SHALL drive ram_we = 1, ram_wem = lsu_req_wem and ram_din = lsu_req_wdata only on an LSU store grant; otherwise ram_we = 0 and ram_wem = 0.
REQ-009 SHALL, on any grant, go to BUSY next cycle with owner = the granted requester, and raise that requester's rsp_valid one cycle after the grant (latency 1).
REQ-010 SHALL present rsp_rdata = ram_dout for reads and 0 for store acks; the rdata of the non-owner SHALL be 0.
REQ-011 SHALL, while BUSY and the owner's rsp_ready is 0, hold rsp_valid and rsp_rdata stable, grant nothing, keep ram_we = 0, and drive ram_addr with the last read address so that ram_dout is unchanged.
REQ-012 SHALL return to IDLE when the response handshakes and no grant occurs in the same cycle.
REQ-013 SHALL maintain starve_cnt: +1 on an LSU grant while ifu_req_valid = 1; cleared on an IFU grant or when ifu_req_valid = 0; saturating at STARVE_LIM.
REQ-014 SHALL sustain one grant per cycle when rsp_ready is held at 1.
REQ-015 SHALL allow request fields to change while the request is not granted; the valid signal SHALL NOT be required to stay high.

Reset
REQ-016 SHALL, on clk edge with rst=1, force state IDLE, owner IFU, starve_cnt 0, and drop any outstanding response.
REQ-017 SHALL drive all outputs to 0 while rst is 1 and in the first cycle after reset; a store granted in the cycle rst is asserted SHALL NOT write (ram_we = 0).

Verification
REQ-018 SHALL pass: IFU read addr 0x10 alone, rsp_ready=1 -> ram_addr=4 at grant, ifu_rsp_valid next cycle with RAM word 4.
REQ-019 SHALL pass: same-cycle IFU read 0x0 and LSU store 0x8, wem=4'b0011, wdata=0xAABBCCDD -> LSU granted, ram_we=1, ram_wem=0011; IFU granted next cycle; lsu_rsp_rdata=0.
REQ-020 SHALL pass: LSU requesting every cycle, IFU valid -> IFU granted on every 5th grant with STARVE_LIM=4.
REQ-021 SHALL pass: lsu_rsp_ready low for 3 cycles after a load -> lsu_rsp_valid and rdata held, both req_ready 0, ram_we 0; grant resumes in the cycle ready rises.
REQ-022 SHALL pass: rst pulsed while BUSY -> rsp_valid 0 next cycle, the response is never delivered, and the next request is granted from IDLE.
REQ-023 SHALL pass: back-to-back IFU reads 0x0, 0x4, 0x8 with rsp_ready=1 -> three consecutive grants and three consecutive responses.

Source files
------------

// File: rtl/tcm_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one single-port TCM; LSU has priority unless IFU is starved.
// Latency: 1 cycle from grant to response. While the response is stalled by rsp_ready=0, no new grant is issued.
module tcm_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MW         = 4,
    parameter int RAM_AW     = 9,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DW-1:0]     ifu_rsp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_req_addr,
    input  logic              lsu_req_we,
    input  logic [MW-1:0]     lsu_req_wem,
    input  logic [DW-1:0]     lsu_req_wdata,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DW-1:0]     lsu_rsp_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    output logic [MW-1:0]     ram_wem,
    input  logic [DW-1:0]     ram_dout
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = LSU owns the outstanding response
    logic              store_q, store_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [RAM_AW-1:0] rd_addr_q, rd_addr_d;
    logic              rst_dly_q, rst_dly_d;

    logic              ifu_own, lsu_own, rsp_done, slot_open;
    logic              grant_ifu, grant_lsu, store_grant;
    logic [RAM_AW-1:0] gnt_addr;
    logic              unused_addr;

    assign unused_addr = ^{ifu_req_addr, lsu_req_addr};

    always_comb begin
        ifu_own     = (state_q == BUSY) && !owner_q && !rst;
        lsu_own     = (state_q == BUSY) && owner_q && !rst;
        rsp_done    = (ifu_own && ifu_rsp_ready) || (lsu_own && lsu_rsp_ready);
        // No grant in the reset cycle nor the cycle right after it.
        slot_open   = !rst && !rst_dly_q && ((state_q == IDLE) || rsp_done);
        grant_ifu   = slot_open && ifu_req_valid && (!lsu_req_valid || (starve_cnt_q == LIM));
        grant_lsu   = slot_open && lsu_req_valid && !grant_ifu;
        store_grant = grant_lsu && lsu_req_we;
        gnt_addr    = grant_lsu ? lsu_req_addr[RAM_AW+1:2] : ifu_req_addr[RAM_AW+1:2];

        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        ifu_rsp_valid = ifu_own;
        lsu_rsp_valid = lsu_own;
        ifu_rsp_rdata = ifu_own ? ram_dout : '0;
        lsu_rsp_rdata = (lsu_own && !store_q) ? ram_dout : '0;

        // Re-presenting the last read address keeps ram_dout stable during a stall.
        if (rst)
            ram_addr = '0;
        else if (grant_ifu || grant_lsu)
            ram_addr = gnt_addr;
        else
            ram_addr = rd_addr_q;
        ram_we  = store_grant;
        ram_wem = store_grant ? lsu_req_wem : '0;
        ram_din = store_grant ? lsu_req_wdata : '0;

        state_d      = state_q;
        owner_d      = owner_q;
        store_d      = store_q;
        rd_addr_d    = rd_addr_q;
        starve_cnt_d = starve_cnt_q;
        rst_dly_d    = rst;

        if (grant_ifu || grant_lsu) begin
            state_d = BUSY;
            owner_d = grant_lsu;
            store_d = store_grant;
            if (!store_grant)
                rd_addr_d = gnt_addr;
        end else if (rsp_done) begin
            state_d = IDLE;
        end

        if (!ifu_req_valid || grant_ifu)
            starve_cnt_d = '0;
        else if (grant_lsu && (starve_cnt_q != LIM))
            starve_cnt_d = starve_cnt_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            store_q      <= 1'b0;
            starve_cnt_q <= '0;
            rd_addr_q    <= '0;
            rst_dly_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            store_q      <= store_d;
            starve_cnt_q <= starve_cnt_d;
            rd_addr_q    <= rd_addr_d;
            rst_dly_q    <= rst_dly_d;
        end
    end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Randomized and directed bench for tcm_arbiter with a behavioural TCM and a response scoreboard.
module tb_tcm_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wem;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_we;
    logic [3:0]  ram_wem;

    tcm_arbiter #(.AW(32), .DW(32), .MW(4), .RAM_AW(9), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wem(lsu_req_wem), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_wem(ram_wem), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [8:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural synchronous-read TCM
    logic [31:0] ram_mem [512];
    logic        ram_vld [512];
    logic        tb_clr;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 512; i++) ram_vld[i] <= 1'b0;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= merge(ram_vld[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr), ram_din, ram_wem);
            ram_vld[ram_addr] <= 1'b1;
        end
        ram_dout <= ram_vld[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
    end

    // Reference model state
    typedef struct { bit lsu; logic [31:0] data; } exp_t;
    exp_t        q[$];
    logic [31:0] m_mem [512];
    bit          m_busy, m_owner_lsu, m_out_read, m_post_rst;
    int          m_starve;
    logic [8:0]  m_last_rd;
    int          tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_chk(input string name);
        chk({name, "_ctl"}, {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, ram_we, ram_wem, ram_addr}, 64'd0);
        chk({name, "_dat"}, {ifu_rsp_rdata, lsu_rsp_rdata}, 64'd0);
        chk({name, "_din"}, ram_din, 64'd0);
    endtask

    // One clock cycle: drive, check combinational response against the model, advance the model.
    task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                        input bit lv, input logic [31:0] la, input bit lwe, input logic [3:0] lwm,
                        input logic [31:0] lwd, input bit irr, input bit lrr, output int g);
        bit hs, open, wi, wl;
        logic [8:0] a;
        @(negedge clk);
        rst = r; ifu_req_valid = iv; ifu_req_addr = ia;
        lsu_req_valid = lv; lsu_req_addr = la; lsu_req_we = lwe; lsu_req_wem = lwm; lsu_req_wdata = lwd;
        ifu_rsp_ready = irr; lsu_rsp_ready = lrr;
        #1;
        g = ifu_req_ready ? 1 : (lsu_req_ready ? 2 : 0);
        if (r) begin
            zero_chk("rst_outs");
            q.delete();
            m_busy = 0; m_starve = 0; m_post_rst = 1;
            return;
        end
        if (m_post_rst) zero_chk("post_rst_outs");
        hs   = m_busy && (m_owner_lsu ? lrr : irr);
        open = !m_post_rst && (!m_busy || hs);
        wi   = open && iv && (!lv || m_starve == LIM);
        wl   = open && lv && !wi;
        a    = wl ? la[10:2] : ia[10:2];
        chk("req_ready", {ifu_req_ready, lsu_req_ready}, {wi, wl});
        chk("rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, {m_busy && !m_owner_lsu, m_busy && m_owner_lsu});
        if (wl && lwe)
            chk("ram_store", {ram_we, ram_wem, ram_din, ram_addr}, {1'b1, lwm, lwd, a});
        else
            chk("ram_nowrite", {ram_we, ram_wem}, 5'd0);
        if (wi || wl)
            chk("ram_addr_gnt", ram_addr, a);
        else if (m_busy && m_out_read)
            chk("ram_addr_hold", ram_addr, m_last_rd);
        if (wi || wl) begin
            q.push_back('{lsu: wl, data: (wl && lwe) ? 32'd0 : m_mem[a]});
            if (wl && lwe) m_mem[a] = merge(m_mem[a], lwd, lwm);
            else m_last_rd = a;
            m_busy = 1; m_owner_lsu = wl; m_out_read = !(wl && lwe);
        end else if (hs) begin
            m_busy = 0;
        end
        if (!iv || wi) m_starve = 0;
        else if (wl && m_starve < LIM) m_starve++;
        m_post_rst = 0;
    endtask

    task automatic idle(output int g);
        step(0, 0, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
    endtask

    // Response monitor: compares every presented response against the scoreboard front.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && (ifu_rsp_valid || lsu_rsp_valid)) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: ifu_vld=%0b lsu_vld=%0b with nothing outstanding", ifu_rsp_valid, lsu_rsp_valid);
                end else begin
                    e = q[0];
                    chk("rsp_channel", {ifu_rsp_valid, lsu_rsp_valid}, e.lsu ? 2'b01 : 2'b10);
                    chk("rsp_rdata", e.lsu ? lsu_rsp_rdata : ifu_rsp_rdata, e.data);
                    chk("nonowner_rdata", e.lsu ? ifu_rsp_rdata : lsu_rsp_rdata, 32'd0);
                    if (e.lsu ? lsu_rsp_ready : ifu_rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int g;
        logic [14:0] pat;
        for (int i = 0; i < 512; i++) m_mem[i] = init_word(9'(i));
        m_busy = 0; m_owner_lsu = 0; m_out_read = 0; m_post_rst = 0; m_starve = 0; m_last_rd = '0;
        rst = 1; tb_clr = 1;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_we = 0; lsu_req_wem = 0; lsu_req_wdata = 0; lsu_rsp_ready = 0;

        // Reset with live requests including a store: nothing may be granted or written.
        step(1, 1, 32'h10, 1, 32'h20, 1, 4'hF, 32'hDEADBEEF, 1, 1, g);
        tb_clr = 0;
        step(1, 1, 32'h10, 1, 32'h20, 1, 4'hF, 32'hDEADBEEF, 1, 1, g);
        step(0, 1, 32'h10, 1, 32'h20, 1, 4'hF, 32'hDEADBEEF, 1, 1, g);
        chk("post_rst_gnt", g, 0);
        idle(g);

        // Lone IFU read of 0x10 -> word 4
        step(0, 1, 32'h10, 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
        chk("t18_gnt", g, 1);
        chk("t18_addr", ram_addr, 9'd4);
        idle(g);

        // Simultaneous IFU read and LSU partial store: LSU first, IFU next cycle
        step(0, 1, 32'h0, 1, 32'h8, 1, 4'b0011, 32'hAABBCCDD, 1, 1, g);
        chk("t19_lsu_first", g, 2);
        step(0, 1, 32'h0, 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
        chk("t19_ifu_next", g, 1);
        idle(g);

        // Starvation: IFU wins every 5th grant
        pat = '0;
        for (int k = 0; k < 15; k++) begin
            step(0, 1, $urandom, 1, $urandom, 0, 4'd0, 32'd0, 1, 1, g);
            pat[k] = (g == 1);
            if (g == 0) chk("t20_grant_each_cycle", g, 1);
        end
        chk("t20_pattern", pat, 15'b100001000010000);
        idle(g);

        // Stalled load response: no grants for 3 cycles, resumes when ready rises
        step(0, 0, 32'd0, 1, 32'h40, 0, 4'd0, 32'd0, 1, 1, g);
        chk("t21_load_gnt", g, 2);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 32'h4, 1, 32'h44, 1, 4'hF, 32'h12345678, 1, 0, g);
            chk("t21_stall_no_gnt", g, 0);
        end
        step(0, 1, 32'h4, 1, 32'h44, 1, 4'hF, 32'h12345678, 1, 1, g);
        chk("t21_resume_gnt", g, 2);
        idle(g);

        // Reset while BUSY drops the outstanding response
        step(0, 1, 32'h80, 0, 32'd0, 0, 4'd0, 32'd0, 0, 0, g);
        chk("t22_gnt", g, 1);
        step(0, 0, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 0, 0, g);
        step(1, 0, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 0, 0, g);
        step(0, 1, 32'h84, 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
        chk("t22_post_rst_valid", ifu_rsp_valid, 1'b0);
        step(0, 1, 32'h84, 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
        chk("t22_regrant", g, 1);
        idle(g);

        // Back-to-back IFU reads
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 32'(4 * k), 0, 32'd0, 0, 4'd0, 32'd0, 1, 1, g);
            chk("t23_b2b_gnt", g, 1);
        end
        idle(g);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 6, $urandom,
                 $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, g);
        end

        for (int k = 0; k < 4; k++) idle(g);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
